// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between the instruction-fetch
// (i-side) and data (d-side) requesters. One owner at a time, address and
// store data captured at grant, per-access timeout and a sticky error flag.
// Optional feature macro: MEM_ARB_FAIR_EN (bounds i-side starvation to
// MAX_WAIT cycles; without it the d-side has strict priority).
module memory_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [1:0]        owner,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // Encoding doubles as the owner code: 0 none, 1 i-side, 2 d-side.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                wen_q, wen_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q;

  logic                d_req;
  logic                own_req;
  logic                done;
  logic                err_set;
  logic                i_starved;
  logic [DATA_W-1:0]   load_data;

  assign d_req = dREN | dWEN;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_WAIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign i_starved = (starve_q >= SW'(MAX_WAIT));

  // Starvation counter: cycles the i-side has waited, saturating at MAX_WAIT.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && state_d == IACC)
      starve_d = '0;
    else if (iREN && state_q != IACC && starve_q < SW'(MAX_WAIT))
      starve_d = starve_q + SW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge CLK) begin
    if (RST) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT > 0);
  assign i_starved       = 1'b0;
`endif

  // Next-state, grant capture and completion/abort decisions.
  always_comb begin
    // NOTE: every comb output gets a default before the case so no path
    // leaves it unassigned and infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    err_set = 1'b0;
    own_req = (state_q == IACC) ? iREN : d_req;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_req && !(iREN && i_starved)) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;
        end else if (iREN) begin
          state_d = IACC;
          addr_d  = iaddr;
          wen_d   = 1'b0;
        end
      end
      IACC, DACC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!own_req) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (ramstate == RAM_ERROR || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done    = 1'b1;
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and sticky error registers.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | err_set;
    end
  end

  // Read data only passes through on a clean completion of a load.
  assign load_data = (done && !err_set && !wen_q) ? ramload : '0;

  assign iload    = (state_q == IACC) ? load_data : '0;
  assign dload    = (state_q == DACC) ? load_data : '0;
  assign iwait    = ~(done && state_q == IACC);
  assign dwait    = ~(done && state_q == DACC);
  assign ramREN   = (state_q != IDLE) && !wen_q;
  assign ramWEN   = (state_q != IDLE) && wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign owner    = state_q;
  assign err      = err_q | err_set;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus for memory_arbiter with a
// transaction-level reference model compared on every negedge, plus
// hand-computed literal expectations for the key scenarios.
module tb_memory_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 4;
  localparam int TMO  = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          iREN, dREN, dWEN;
  logic [AW-1:0] iaddr, daddr, ramaddr;
  logic [DW-1:0] dstore, iload, dload, ramstore, ramload;
  logic          iwait, dwait, ramREN, ramWEN, err;
  logic [1:0]    ramstate, owner;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .owner(owner), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_owner  = 0;     // 0 none, 1 i-side, 2 d-side
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_store  = '0;
  bit            m_wr     = 1'b0;
  bit            m_err    = 1'b0;
  int            m_age    = 0;     // access cycles already spent by current owner
  int            m_starve = 0;
  bit            chk_en   = 1'b0;

  function automatic bit m_req_own();
    if (m_owner == 1) return iREN;
    if (m_owner == 2) return dREN | dWEN;
    return 1'b0;
  endfunction

  function automatic bit m_fin();
    return (m_owner != 0) && m_req_own() &&
           (ramstate == 2'd2 || ramstate == 2'd3 || m_age + 1 >= TMO);
  endfunction

  function automatic bit m_bad();
    return m_fin() && ramstate != 2'd2;
  endfunction

  // Model advances on each rising edge using the inputs held that cycle.
  always @(posedge CLK) begin
    bit dreq, pick_i;
    if (RST) begin
      m_owner = 0; m_addr = '0; m_store = '0; m_wr = 0;
      m_err = 0; m_age = 0; m_starve = 0;
    end else begin
      dreq = dREN | dWEN;
`ifdef MEM_ARB_FAIR_EN
      pick_i = iREN && (!dreq || m_starve >= MAXW);
`else
      pick_i = iREN && !dreq;
`endif
      if (iREN && m_owner != 1) m_starve++;
      if (m_owner == 0) begin
        m_age = 0;
        if (dreq && !pick_i) begin
          m_owner = 2; m_addr = daddr; m_store = dstore; m_wr = dWEN;
        end else if (iREN) begin
          m_owner = 1; m_addr = iaddr; m_wr = 0; m_starve = 0;
        end
      end else begin
        if (m_bad()) m_err = 1;
        if (!m_req_own() || m_fin()) m_owner = 0;
        m_age++;
      end
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge CLK) begin
    bit fin, bad;
    if (chk_en) begin
      fin = m_fin();
      bad = m_bad();
      check("m_iwait",    iwait,    !(fin && m_owner == 1));
      check("m_dwait",    dwait,    !(fin && m_owner == 2));
      check("m_iload",    iload,    (fin && !bad && m_owner == 1) ? ramload : '0);
      check("m_dload",    dload,    (fin && !bad && m_owner == 2 && !m_wr) ? ramload : '0);
      check("m_ramREN",   ramREN,   m_owner != 0 && !m_wr);
      check("m_ramWEN",   ramWEN,   m_owner != 0 && m_wr);
      check("m_ramaddr",  ramaddr,  m_addr);
      check("m_ramstore", ramstore, m_store);
      check("m_owner",    owner,    m_owner[1:0]);
      check("m_err",      err,      m_err | bad);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_at, first_i;
    RST = 1; idle_inputs();
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    step(); chk_en = 1;
    step(); RST = 0;

    // Reset values.
    @(negedge CLK);
    check("rst_owner",   owner, 2'd0);
    check("rst_iwait",   iwait, 1'b1);
    check("rst_dwait",   dwait, 1'b1);
    check("rst_ramREN",  ramREN, 1'b0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_err",     err, 1'b0);

    // Write with two BUSY cycles; address changes after grant are ignored.
    step(); dWEN = 1; daddr = 32'h40; dstore = 32'hDEADBEEF; ramstate = 2'd1;
    step(); daddr = 32'h99; dstore = 32'h0;
    @(negedge CLK);
    check("wr_ramWEN",  ramWEN, 1'b1);
    check("wr_ramaddr", ramaddr, 32'h40);
    check("wr_owner",   owner, 2'd2);
    step();
    step(); ramstate = 2'd2;
    @(negedge CLK);
    check("wr_dwait",    dwait, 1'b0);
    check("wr_ramstore", ramstore, 32'hDEADBEEF);
    step(); dWEN = 0; ramstate = 2'd0;
    @(negedge CLK);
    check("wr_owner_back", owner, 2'd0);

    // Simultaneous requests: d-side first (cycle 1), i-side next (cycle 3).
    step(); iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200;
    ramstate = 2'd2; ramload = 32'h12345678;
    step();
    @(negedge CLK);
    check("both_dwait", dwait, 1'b0);
    check("both_dload", dload, 32'h12345678);
    check("both_iwait", iwait, 1'b1);
    step(); dREN = 0;
    @(negedge CLK);
    check("both_gap_owner", owner, 2'd0);
    step(); ramload = 32'hCAFEF00D;
    @(negedge CLK);
    check("both_iwait2", iwait, 1'b0);
    check("both_iload",  iload, 32'hCAFEF00D);
    check("both_iaddr",  ramaddr, 32'h100);
    step(); iREN = 0; ramstate = 2'd0;

    // RAM error on a d-side read.
    step(); dREN = 1; daddr = 32'h300; ramstate = 2'd3;
    step();
    @(negedge CLK);
    check("rerr_dwait", dwait, 1'b0);
    check("rerr_dload", dload, 32'h0);
    check("rerr_err",   err, 1'b1);
    step(); dREN = 0; ramstate = 2'd0;

    // Requester abort: wait stays 1, owner returns to none.
    step(); dREN = 1; ramstate = 2'd1;
    step();
    step(); dREN = 0;
    @(negedge CLK);
    check("abort_dwait", dwait, 1'b1);
    step();
    @(negedge CLK);
    check("abort_owner", owner, 2'd0);
    check("abort_err_sticky", err, 1'b1);

    // Only reset clears the sticky error.
    step(); RST = 1;
    step(); RST = 0;
    @(negedge CLK);
    check("err_cleared", err, 1'b0);

    // Timeout: ramstate held BUSY, completion on the 8th access cycle.
    step(); iREN = 1; iaddr = 32'h500; ramstate = 2'd1;
    done_at = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      if (iwait === 1'b0) begin
        done_at = k;
        check("tmo_iload", iload, 32'h0);
        check("tmo_err",   err, 1'b1);
        break;
      end
      step();
    end
    check("tmo_cycle", done_at, 8);
    step(); iREN = 0; ramstate = 2'd0;
    step(); step();
    @(negedge CLK);
    check("tmo_err_sticky", err, 1'b1);

    // Reset in the middle of a d-side access.
    step(); RST = 1;
    step(); RST = 0; dREN = 1; daddr = 32'h600; ramstate = 2'd1;
    step();
    @(negedge CLK);
    check("mid_owner_pre", owner, 2'd2);
    step(); RST = 1;
    step(); RST = 0; dREN = 0;
    @(negedge CLK);
    check("mid_ramREN", ramREN, 1'b0);
    check("mid_dwait",  dwait, 1'b1);
    check("mid_owner",  owner, 2'd0);

    // Continuous d-side reads with a pending i-side request.
    step(); RST = 1;
    step(); RST = 0; iREN = 1; dREN = 1; iaddr = 32'h700; daddr = 32'h800;
    ramstate = 2'd2; ramload = 32'h0BADC0DE;
    first_i = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (owner === 2'd1 && first_i < 0) first_i = k;
      step();
    end
`ifdef MEM_ARB_FAIR_EN
    check("fair_first_i", first_i, 5);
`else
    check("strict_no_i", first_i, -1);
`endif
    idle_inputs();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
